// File: rtl/facto_pkg.sv
// Shared register map and FSM encoding for the factorial-core host.
package facto_pkg;

    localparam logic [15:0] A_OPSTART  = 16'h7000;
    localparam logic [15:0] A_OPCLEAR  = 16'h7008;
    localparam logic [15:0] A_OPDONE   = 16'h7010;
    localparam logic [15:0] A_INTREN   = 16'h7018;
    localparam logic [15:0] A_OPERAND  = 16'h7020;
    localparam logic [15:0] A_RESULT_H = 16'h7028;
    localparam logic [15:0] A_RESULT_L = 16'h7030;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_INTR,
        S_W_OPND,
        S_W_START,
        S_WAIT,
        S_R_H,
        S_R_L,
        S_CLR1,
        S_CLR0,
        S_OUT
    } state_t;

endpackage

// File: rtl/facto_wdt.sv
// Wait-for-interrupt watchdog: counts WAIT cycles, flags TIMEOUT-1.
module facto_wdt #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(TIMEOUT - 1));

    // Saturates at terminal count so it can never wrap back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/facto_host.sv
// Host sequencer: programs the factorial core over a simple bus,
// waits for its interrupt (with timeout) and returns a 128-bit result.
module facto_host
    import facto_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_operand,
    output logic        m_sel,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_h,
    output logic [63:0] res_l,
    output logic        res_err
);

    state_t      state_q;
    state_t      state_d;
    logic [63:0] opnd;
    logic        tc;
    logic        accept;
    logic        timeout;

    assign accept  = (state_q == S_IDLE) && cmd_valid && cmd_ready;
    assign timeout = (state_q == S_WAIT) && !interrupt && tc;

    facto_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state_q == S_W_START),
        .enable (state_q == S_WAIT),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept) state_d = S_W_INTR;
            S_W_INTR:  state_d = S_W_OPND;
            S_W_OPND:  state_d = S_W_START;
            S_W_START: state_d = S_WAIT;
            S_WAIT: begin
                if (interrupt) state_d = S_R_H;
                else if (tc)   state_d = S_CLR1;
            end
            S_R_H:     state_d = S_R_L;
            S_R_L:     state_d = S_CLR1;
            S_CLR1:    state_d = S_CLR0;
            S_CLR0:    state_d = S_OUT;
            S_OUT:     if (res_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_sel  = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_dout = '0;
        unique case (state_q)
            S_W_INTR: begin
                m_sel  = 1'b1;
                m_wr   = 1'b1;
                m_addr = A_INTREN;
                m_dout = 64'd1;
            end
            S_W_OPND: begin
                m_sel  = 1'b1;
                m_wr   = 1'b1;
                m_addr = A_OPERAND;
                m_dout = opnd;
            end
            S_W_START: begin
                m_sel  = 1'b1;
                m_wr   = 1'b1;
                m_addr = A_OPSTART;
                m_dout = 64'd1;
            end
            S_R_H: begin
                m_sel  = 1'b1;
                m_addr = A_RESULT_H;
            end
            S_R_L: begin
                m_sel  = 1'b1;
                m_addr = A_RESULT_L;
            end
            S_CLR1: begin
                m_sel  = 1'b1;
                m_wr   = 1'b1;
                m_addr = A_OPCLEAR;
                m_dout = 64'd1;
            end
            S_CLR0: begin
                m_sel  = 1'b1;
                m_wr   = 1'b1;
                m_addr = A_OPCLEAR;
            end
            default: begin
            end
        endcase
    end

    // Handshake flags follow the next state so they stay 0 during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
            opnd      <= '0;
            res_h     <= '0;
            res_l     <= '0;
            res_err   <= 1'b0;
        end else begin
            cmd_ready <= (state_d == S_IDLE);
            res_valid <= (state_d == S_OUT);
            if (accept) begin
                opnd    <= cmd_operand;
                res_err <= 1'b0;
            end
            if (timeout) begin
                res_err <= 1'b1;
                res_h   <= '0;
                res_l   <= '0;
            end
            if (state_q == S_R_H) res_h <= m_din;
            if (state_q == S_R_L) res_l <= m_din;
        end
    end

endmodule

// File: tb/tb_facto_host.sv
// Directed bench for facto_host: behavioural core on instance u0,
// hand-driven interrupt on a short-timeout instance u1.
module tb_facto_host;
    import facto_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---- instance u0 (default TIMEOUT) with core model
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_operand = '0;
    logic        m_sel, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout, m_din;
    logic        interrupt;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_h, res_l;
    logic        res_err;

    facto_host u0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_operand(cmd_operand),
        .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .m_din(m_din),
        .interrupt(interrupt),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_h(res_h), .res_l(res_l), .res_err(res_err)
    );

    // ---- instance u1 (TIMEOUT=16), interrupt driven by the bench
    logic        cmd_valid1 = 1'b0;
    logic        cmd_ready1;
    logic [63:0] cmd_operand1 = '0;
    logic        m_sel1, m_wr1;
    logic [15:0] m_addr1;
    logic [63:0] m_dout1, m_din1;
    logic        intr1 = 1'b0;
    logic        res_valid1;
    logic        res_ready1 = 1'b0;
    logic [63:0] res_h1, res_l1;
    logic        res_err1;

    facto_host #(.TIMEOUT(16)) u1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_operand(cmd_operand1),
        .m_sel(m_sel1), .m_wr(m_wr1), .m_addr(m_addr1),
        .m_dout(m_dout1), .m_din(m_din1),
        .interrupt(intr1),
        .res_valid(res_valid1), .res_ready(res_ready1),
        .res_h(res_h1), .res_l(res_l1), .res_err(res_err1)
    );

    assign m_din1 = (m_addr1 == A_RESULT_H) ? 64'h1111_2222_3333_4444 :
                    (m_addr1 == A_RESULT_L) ? 64'h5555_6666_7777_8888 : 64'd0;

    // ---- behavioural factorial core for u0
    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    logic [63:0]  c_opnd;
    logic         c_ien, c_done, c_busy;
    logic [127:0] c_res;
    int           c_cnt;
    int           core_lat = 4;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_opnd <= '0; c_ien <= 1'b0; c_done <= 1'b0;
            c_busy <= 1'b0; c_res <= '0; c_cnt <= 0;
        end else begin
            if (c_busy) begin
                if (c_cnt <= 1) begin
                    c_busy <= 1'b0;
                    c_done <= 1'b1;
                    c_res  <= fact(c_opnd);
                end else begin
                    c_cnt <= c_cnt - 1;
                end
            end
            if (m_sel && m_wr) begin
                case (m_addr)
                    A_INTREN:  c_ien  <= m_dout[0];
                    A_OPERAND: c_opnd <= m_dout;
                    A_OPSTART: if (m_dout[0]) begin
                        c_busy <= 1'b1; c_cnt <= core_lat; c_done <= 1'b0;
                    end
                    A_OPCLEAR: if (m_dout[0]) begin
                        c_busy <= 1'b0; c_done <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign interrupt = c_done & c_ien;

    always_comb begin
        m_din = '0;
        if (m_addr == A_RESULT_H) m_din = c_res[127:64];
        else if (m_addr == A_RESULT_L) m_din = c_res[63:0];
        else if (m_addr == A_OPDONE) m_din = {63'd0, c_done};
    end

    // ---- bus traces
    logic [80:0] tr0[$];
    logic [80:0] tr1[$];
    always @(posedge clk) begin
        if (m_sel)  tr0.push_back({m_wr, m_addr, m_dout});
        if (m_sel1) tr1.push_back({m_wr1, m_addr1, m_dout1});
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run0(input logic [63:0] op, input bit ack,
                        output logic [63:0] h, output logic [63:0] l,
                        output logic e, output int wt);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        wt = n;
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_operand = op;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 500) begin @(negedge clk); n++; end
        chk("res_valid_wait", res_valid, 1);
        h = res_h; l = res_l; e = res_err;
        if (ack) begin
            res_ready = 1'b1; @(posedge clk); #1 res_ready = 1'b0;
        end
    endtask

    task automatic get1(output logic [63:0] h, output logic [63:0] l,
                        output logic e);
        int n = 0;
        @(negedge clk);
        while (!res_valid1 && n < 500) begin @(negedge clk); n++; end
        chk("res_valid1_wait", res_valid1, 1);
        h = res_h1; l = res_l1; e = res_err1;
        res_ready1 = 1'b1; @(posedge clk); #1 res_ready1 = 1'b0;
    endtask

    typedef struct {
        logic [63:0] op;
        logic [63:0] h;
        logic [63:0] l;
    } vec_t;

    initial begin
        vec_t         vt[6];
        logic [127:0] f25;
        logic [63:0]  h, l, h0, l0;
        logic         e;
        int           wt, bad, rd;

        f25 = 128'd15511210043330985984000000;
        vt[0] = '{64'd5,  64'd0, 64'd120};
        vt[1] = '{64'd0,  64'd0, 64'd1};
        vt[2] = '{64'd20, 64'd0, 64'd2432902008176640000};
        vt[3] = '{64'd3,  64'd0, 64'd6};
        vt[4] = '{64'd10, 64'd0, 64'd3628800};
        vt[5] = '{64'd25, f25[127:64], f25[63:0]};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ctl", {cmd_ready, m_sel, m_wr, m_addr, res_valid, res_err}, 0);
        chk("rst_data", {m_dout, res_h, res_l}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {cmd_ready, cmd_ready1}, 2'b11);

        // bus trace for operand 5
        tr0.delete();
        run0(64'd5, 1'b1, h, l, e, wt);
        chk("op5_h", h, 0);
        chk("op5_l", l, 120);
        chk("op5_err", e, 0);
        chk("op5_trace_len", tr0.size(), 7);
        if (tr0.size() == 7) begin
            chk("tr_intren", tr0[0], {1'b1, A_INTREN, 64'd1});
            chk("tr_operand", tr0[1], {1'b1, A_OPERAND, 64'd5});
            chk("tr_opstart", tr0[2], {1'b1, A_OPSTART, 64'd1});
            chk("tr_rd_h", tr0[3], {1'b0, A_RESULT_H, 64'd0});
            chk("tr_rd_l", tr0[4], {1'b0, A_RESULT_L, 64'd0});
            chk("tr_clr1", tr0[5], {1'b1, A_OPCLEAR, 64'd1});
            chk("tr_clr0", tr0[6], {1'b1, A_OPCLEAR, 64'd0});
        end

        // table of operands
        for (int i = 0; i < 6; i++) begin
            run0(vt[i].op, 1'b1, h, l, e, wt);
            chk($sformatf("vec%0d_h", i), h, vt[i].h);
            chk($sformatf("vec%0d_l", i), l, vt[i].l);
            chk($sformatf("vec%0d_err", i), e, 0);
        end

        // back-to-back: 0 then 20
        run0(64'd0, 1'b1, h, l, e, wt);
        chk("b2b0_l", l, 1);
        run0(64'd20, 1'b1, h, l, e, wt);
        chk("b2b_ready_now", wt, 0);
        chk("b2b20_res", {h, l}, {64'd0, 64'd2432902008176640000});

        // result held while consumer stalls
        run0(64'd25, 1'b0, h0, l0, e, wt);
        chk("hold_val", {h0, l0}, f25);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!res_valid || res_h !== h0 || res_l !== l0 || cmd_ready)
                bad++;
        end
        chk("hold_stable", bad, 0);
        res_ready = 1'b1; @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        chk("hold_release", {cmd_ready, res_valid}, 2'b10);

        // u1: interrupt coincident with terminal count
        @(negedge clk);
        cmd_valid1 = 1'b1; cmd_operand1 = 64'd4;
        @(posedge clk); #1 cmd_valid1 = 1'b0;
        repeat (18) @(posedge clk);
        #1 intr1 = 1'b1;
        chk("coinc_in_wait", m_sel1, 0);
        @(posedge clk); #1 intr1 = 1'b0;
        get1(h, l, e);
        chk("coinc_err", e, 0);
        chk("coinc_res", {h, l},
            {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888});

        // u1: timeout with interrupt stuck low
        tr1.delete();
        @(negedge clk);
        cmd_valid1 = 1'b1; cmd_operand1 = 64'd9;
        @(posedge clk); #1 cmd_valid1 = 1'b0;
        get1(h, l, e);
        chk("to_err", e, 1);
        chk("to_res", {h, l}, 0);
        rd = 0;
        foreach (tr1[i]) if (!tr1[i][80]) rd++;
        chk("to_no_reads", rd, 0);
        chk("to_trace_len", tr1.size(), 5);
        if (tr1.size() == 5) begin
            chk("to_clr1", tr1[3], {1'b1, A_OPCLEAR, 64'd1});
            chk("to_clr0", tr1[4], {1'b1, A_OPCLEAR, 64'd0});
        end

        // reset pulse mid-WAIT
        core_lat = 100;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_operand = 64'd7;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {cmd_ready, m_sel, m_wr, m_addr, res_valid, res_err}, 0);
        chk("mid_rst_data", {m_dout, res_h, res_l}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        core_lat = 4;
        @(negedge clk);
        chk("mid_rst_ready", cmd_ready, 1);
        run0(64'd3, 1'b1, h, l, e, wt);
        chk("after_rst_res", {h, l, 63'd0, e}, {64'd0, 64'd6, 64'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/facto_host.md
FACTO_HOST -- requirements
Module: facto_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, the maximum number of cycles spent waiting for interrupt before aborting.
REQ-002 SHALL have ports:
  clk  input  1  single clock; all state updates on the rising edge
  reset_n  input  1  asynchronous active-low reset
  cmd_valid  input  1  request to compute operand!
  cmd_ready  output  1  block idle and able to accept a command
  cmd_operand  input  64  factorial operand
  m_sel  output  1  bus select to the factorial core
  m_wr  output  1  1 = write, 0 = read
  m_addr  output  16  bus address
  m_dout  output  64  write data to the core
  m_din  input  64  read data from the core, combinational, valid in the same cycle as the read address
  interrupt  input  1  core done interrupt
  res_valid  output  1  result held and valid
  res_ready  input  1  consumer accepts the result
  res_h  output  64  result bits 127:64
  res_l  output  64  result bits 63:0
  res_err  output  1  result aborted by timeout; res_h and res_l are 0

Function
REQ-003 SHALL use a core register map of OPSTART 0x7000, OPCLEAR 0x7008, OPDONE 0x7010, INTREN 0x7018, OPERAND 0x7020, RESULT_H 0x7028 and RESULT_L 0x7030.
REQ-004 SHALL implement the FSM states IDLE, W_INTR, W_OPND, W_START, WAIT, R_H, R_L, CLR1, CLR0 and OUT, with exactly one bus access per bus state and one cycle per bus state.
REQ-005 SHALL assert cmd_ready only in IDLE, and SHALL accept a command on cmd_valid&cmd_ready by latching cmd_operand and moving to W_INTR.
REQ-006 SHALL perform these bus writes, each with m_sel=1 and m_wr=1:
  W_INTR: INTREN <- 1
  W_OPND: OPERAND <- latched operand
  W_START: OPSTART <- 1
REQ-007 SHALL hold m_sel=0 in WAIT.
REQ-008 SHALL leave WAIT for R_H on the first cycle that interrupt=1.
REQ-009 SHALL in R_H and R_L drive m_sel=1 and m_wr=0 with address RESULT_H or RESULT_L, and capture m_din into the res_h or res_l holding register at the end of that cycle.
REQ-010 SHALL in CLR1 write OPCLEAR <- 1 and in CLR0 write OPCLEAR <- 0, which leaves the core idle with interrupt deasserted.
REQ-011 SHALL assert res_valid only in OUT, hold res_h, res_l and res_err stable until res_valid&res_ready, then return to IDLE on the next edge.
REQ-012 SHALL accept a new command no earlier than the cycle after the OUT handshake; minimum command-to-res_valid latency is 9 cycles plus wait cycles.
REQ-013 SHALL run a wait counter that clears on entry to WAIT and increments each WAIT cycle.
REQ-014 SHALL, when the wait counter reaches TIMEOUT-1 with interrupt=0, set res_err=1, zero res_h and res_l, and go to CLR1, skipping the reads.
REQ-015 SHALL give interrupt priority when interrupt=1 and the timeout occur in the same cycle (no error).
REQ-016 SHALL drive m_addr=0, m_dout=0, m_wr=0 and m_sel=0 in every non-bus state.
REQ-017 SHALL ignore interrupt outside WAIT.
REQ-018 SHALL ignore cmd_valid outside IDLE; the command is neither lost nor latched and stays pending at the source.
REQ-019 SHALL clear res_err on acceptance of the next command.

Reset
REQ-020 SHALL on reset_n=0, at any time and in any state, asynchronously enter IDLE and clear the operand, holding registers, counter and res_err.
REQ-021 SHALL while in reset drive cmd_ready=0, m_sel=0, m_wr=0, m_addr=0, m_dout=0, res_valid=0, res_h=0, res_l=0 and res_err=0.
REQ-022 SHALL drive cmd_ready=1 from the first cycle after reset release.
REQ-023 SHALL not resume an interrupted sequence after reset; the core is assumed reset by the same reset_n.

Structure
REQ-024 SHALL place the register-map address constants and the FSM state encoding in the shared package facto_pkg.
REQ-025 SHALL implement the wait counter as sub-module facto_wdt (clear, enable, terminal-count output, parameter TIMEOUT).
REQ-026 SHALL use registered outputs; only the bus outputs decode combinationally from the state register.

Verification
REQ-027 SHALL verify: operand 5, TIMEOUT default -> bus trace INTREN=1, OPERAND=5, OPSTART=1, reads H then L, OPCLEAR=1 then 0; res_h=0, res_l=120, res_err=0.
REQ-028 SHALL verify: operand 0, then operand 20 back-to-back -> res_l=1, then res_l=2432902008176640000 with res_h=0.
REQ-029 SHALL verify: operand 25 with res_ready=0 for 50 cycles -> res_valid held and res_h/res_l constant; cmd_ready=0 throughout; handshake releases to IDLE.
REQ-030 SHALL verify: interrupt tied to 0 with TIMEOUT=16 -> res_err=1, res_h=res_l=0, no RESULT reads, OPCLEAR written 1 then 0.
REQ-031 SHALL verify: reset_n low for 1 cycle mid-WAIT -> all outputs 0 immediately; cmd_ready=1 the cycle after release; a new operand 3 yields res_l=6.
REQ-032 SHALL verify: interrupt and timeout coincident at TIMEOUT-1 -> normal read path, res_err=0.
